mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Two-port arbiter/sequencer in front of the single-port word memory. Shares it between
//   the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
//   Drives the memory's re/we strobes, captures read data and returns one-cycle acks.
//   Round-robin arbitration; watchdog timeout on memory rdy.
// PARAMETERS
//   AW       32  address width, word address, passed straight to memory
//   DW       32  data width
//   TIMEOUT  15  max WAIT cycles for mem_rdy before error completion, 1..255
// PORTS
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   i_req      in   1   fetch request; hold with i_addr stable until i_ack
//   i_addr     in   AW  fetch word address
//   i_ack      out  1   one-cycle pulse: fetch complete, i_rdata/i_err valid
//   i_rdata    out  DW  fetched word; held until next I completion
//   i_err      out  1   valid with i_ack: timeout, i_rdata unchanged
//   d_req      in   1   data request; hold with d_we/d_addr/d_wdata stable until d_ack
//   d_we       in   1   1 = write, 0 = read
//   d_addr     in   AW  data word address
//   d_wdata    in   DW  write data
//   d_ack      out  1   one-cycle pulse: data access complete
//   d_rdata    out  DW  read word (reads only); held until next D read completion
//   d_err      out  1   valid with d_ack: timeout
//   mem_re     out  1   memory read strobe
//   mem_we     out  1   memory write strobe
//   mem_addr   out  AW  memory address, registered
//   mem_wdata  out  DW  memory write data, registered
//   mem_rdata  in   DW  memory read data
//   mem_rdy    in   1   memory ready; cleared by memory on re/we rise, set on the clk edge it serves
//   busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//   Reset (async, rst=1): state IDLE, all outputs 0 (acks, errs, strobes, mem_addr, mem_wdata,
//     i_rdata, d_rdata, busy), last_grant=D so I wins the first contest, timeout counter 0.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: requests sampled only here. One requester: grant it. Both: grant the port not in
//     last_grant. Latch owner, we, addr, wdata into mem_addr/mem_wdata; update last_grant.
//   ISSUE (exactly 1 cycle): mem_re=1 for a read (all I; D with d_we=0), mem_we=1 for a D
//     write. Never both. Timeout counter cleared.
//   WAIT: strobes 0. mem_rdy=1 -> capture mem_rdata for a read, go RESP, err=0.
//     Else count++. Count reaches TIMEOUT -> RESP with err=1, no data captured.
//   RESP (1 cycle): owner's ack=1, err as determined; others 0. Read data on i_rdata/d_rdata
//     from this cycle. D write leaves d_rdata unchanged. Then IDLE.
//   Latency: req high in IDLE cycle t -> ack in cycle t+3 (mem_rdy on first WAIT cycle).
//     Min 4 cycles per access; back-to-back alternation when both ports stay requesting.
//   Handshake: requester drops req on the edge ending its ack cycle unless it wants another
//     access. req still high in the next IDLE cycle = new request.
//   Fairness: a waiting requester is served after at most one access by the other port.
//   req dropped after grant: access still completes and ack still pulses; requester ignores it.
//   Non-owner req changes during an access: no effect until next IDLE.
//   rst mid-access: immediate abort, no ack, strobes drop asynchronously. Memory contents are
//     unspecified for an aborted write.
//   Address/data pass through unmodified at full AW/DW width. No range check; memory owns decode.
// TESTING
//   1 rst pulse mid-run -> all outputs 0, busy=0; next I read of addr 0 returns the memory word.
//   2 D write addr 5 data 0xDEADBEEF, then I read addr 5 -> d_ack, d_err=0; i_rdata=0xDEADBEEF
//     at t+3; exactly one mem_we and one mem_re cycle.
//   3 i_req and d_req rise together, both held -> grants I,D,I,D; acks 4 cycles apart.
//   4 Memory model holds mem_rdy=0, TIMEOUT=15 -> ack with err=1 after 15 WAIT cycles,
//     rdata unchanged.
//   5 rst asserted in WAIT of a D write -> no d_ack; after release state IDLE; new read serviced.
//   6 d_req dropped in ISSUE -> d_ack still pulses once; no second access issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port word memory between an instruction-fetch port (I,
//   read-only) and a load/store port (D, read/write). Each access runs
//   IDLE -> ISSUE -> WAIT -> RESP. Contested grants alternate round-robin.
//   A watchdog ends an access with an error if the memory never reports ready.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_req, i_addr     fetch request and word address (held until i_ack)
//   i_ack, i_rdata,   one-cycle completion pulse, fetched word (held until the
//   i_err             next I completion), timeout flag valid with i_ack
//   d_req, d_we,      data request, write enable, word address and write data
//   d_addr, d_wdata   (held until d_ack)
//   d_ack, d_rdata,   one-cycle completion pulse, read word (held until the
//   d_err             next D read completion), timeout flag valid with d_ack
//   mem_re, mem_we    memory read / write strobes, asserted for one cycle
//   mem_addr,         registered memory address and write data
//   mem_wdata
//   mem_rdata,        memory read data and ready
//   mem_rdy
//   busy              high whenever an access is in progress

module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic       owner_d;
  logic       last_grant_d;
  logic       op_we;
  logic       err_flag;
  logic [7:0] wait_count;
  logic       grant_valid;
  logic       grant_d;
  logic       wait_expired;

  // The WAIT cycle currently being spent is the last one the watchdog allows.
  assign wait_expired = (wait_count + 8'd1) == TIMEOUT_LIMIT;

  // State register; reset aborts any access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, grant decision and the combinational strobes/acks.
  always_comb begin
    state_next  = state;
    grant_valid = 1'b0;
    grant_d     = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    i_ack       = 1'b0;
    i_err       = 1'b0;
    d_ack       = 1'b0;
    d_err       = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_valid = 1'b1;
          // On a contest the port that did not win last time is served.
          grant_d     = d_req && (!i_req || !last_grant_d);
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        mem_re     = !op_we;
        mem_we     = op_we;
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_rdy || wait_expired) begin
          state_next = RESP;
        end
      end
      RESP: begin
        i_ack      = !owner_d;
        i_err      = !owner_d && err_flag;
        d_ack      = owner_d;
        d_err      = owner_d && err_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Access bookkeeping: owner, latched address/data, watchdog and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d      <= 1'b0;
      last_grant_d <= 1'b1;
      op_we        <= 1'b0;
      err_flag     <= 1'b0;
      wait_count   <= 8'd0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            op_we        <= grant_d && d_we;
            mem_addr     <= grant_d ? d_addr : i_addr;
            if (grant_d) begin
              mem_wdata <= d_wdata;
            end
          end
        end
        ISSUE: begin
          wait_count <= 8'd0;
          err_flag   <= 1'b0;
        end
        WAIT: begin
          if (mem_rdy) begin
            err_flag <= 1'b0;
            if (!op_we) begin
              if (owner_d) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
          end else if (wait_expired) begin
            err_flag <= 1'b1;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
